// File: rtl/mandelbrot_pkg.sv
// Shared widths, state encoding and raster addressing for the Mandelbrot frame scheduler.
package mandelbrot_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned PASS_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned raster_addr(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y,
                                              input int unsigned        resx);
    return 32'(y) * resx + 32'(x);
  endfunction

endpackage

// File: rtl/mandelbrot_raster_counter.sv
// Raster-order x/y counter; wrap pulses when the last pixel of a frame is stepped over.
module mandelbrot_raster_counter
  import mandelbrot_pkg::*;
#(
  parameter int unsigned RESX = 32,
  parameter int unsigned RESY = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               wrap
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               x_last, y_last;

  assign x_last = (x_q == COORD_W'(RESX - 1));
  assign y_last = (y_q == COORD_W'(RESY - 1));
  assign wrap   = en && x_last && y_last;
  assign x      = x_q;
  assign y      = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: issues pixels in raster order for N passes, tracks retirements and
// stalls issue so a pixel is never re-read before its previous pass is written back.
module mandelbrot_scheduler
  import mandelbrot_pkg::*;
#(
  parameter  int unsigned RESX   = 32,
  parameter  int unsigned RESY   = 32,
  localparam int unsigned PIXELS = RESX * RESY,
  localparam int unsigned AW     = $clog2(PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PASS_W-1:0]  passes,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               pvalid,
  output logic [COORD_W-1:0] xin,
  output logic [COORD_W-1:0] yin,
  output logic               pin_sel,
  output logic [AW-1:0]      rd_addr,
  output logic [PASS_W-1:0]  pass,
  input  logic               output_ready,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr
);

  localparam logic [AW:0] PIX_CNT = (AW + 1)'(PIXELS);

  state_e             state_q, state_d;
  logic [PASS_W-1:0]  passes_q, passes_d, pass_q, pass_d;
  logic [AW:0]        inflight_q, inflight_d;
  logic               err_q, err_d, done_q, done_d;
  logic               issue, ret, clr, iss_wrap, ret_wrap;
  logic [COORD_W-1:0] xout, yout;

  assign busy    = (state_q != IDLE);
  assign issue   = (state_q == ISSUE) && (inflight_q < PIX_CNT);
  assign clr     = (state_q == IDLE) && start;
  assign wr_en   = output_ready && busy;
  // A retire with nothing in flight is spurious and must not move any counter.
  assign ret     = wr_en && (inflight_q != '0);
  assign pvalid  = issue;
  assign pin_sel = (pass_q != '0);
  assign pass    = pass_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_addr = AW'(raster_addr(xin, yin, RESX));
  assign wr_addr = AW'(raster_addr(xout, yout, RESX));

  mandelbrot_raster_counter #(.RESX(RESX), .RESY(RESY)) u_issue_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (issue),
    .x    (xin),
    .y    (yin),
    .wrap (iss_wrap)
  );

  mandelbrot_raster_counter #(.RESX(RESX), .RESY(RESY)) u_retire_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (ret),
    .x    (xout),
    .y    (yout),
    .wrap (ret_wrap)
  );

  always_comb begin
    state_d    = state_q;
    passes_d   = passes_q;
    pass_d     = pass_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (output_ready) err_d = 1'b1;
        if (start) begin
          state_d    = ISSUE;
          passes_d   = (passes == '0) ? PASS_W'(1) : passes;
          pass_d     = '0;
          inflight_d = '0;
          err_d      = 1'b0;
        end
      end
      ISSUE, DRAIN: begin
        if (wr_en && (inflight_q == '0)) err_d = 1'b1;
        case ({issue, ret})
          2'b10:   inflight_d = inflight_q + (AW + 1)'(1);
          2'b01:   inflight_d = inflight_q - (AW + 1)'(1);
          default: inflight_d = inflight_q;
        endcase
        if (iss_wrap) begin
          pass_d = pass_q + PASS_W'(1);
          if (pass_q == passes_q - PASS_W'(1)) state_d = DRAIN;
        end
        // The final retire of a frame also closes the retire raster.
        if ((state_q == DRAIN) && ret && ret_wrap && (inflight_q == (AW + 1)'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      passes_q   <= '0;
      pass_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      passes_q   <= passes_d;
      pass_q     <= pass_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/mandelbrot_scheduler.md
# mandelbrot_scheduler

Frame scheduler for the pipelined Mandelbrot datapath. On `start` it streams pixel coordinates into the pipeline in raster order for a programmed number of passes. Pass 0 feeds zero state; later passes feed back each pixel's stored state from the framebuffer. It counts pipeline retirements to produce framebuffer write addresses, and stalls issue so that a pixel is never re-read before its previous pass has been written back. It sits between the top-level control and the `mandelbrot` core plus its framebuffer RAM.

## Interface
- `RESX`, 32, pixels per line (≥2)
- `RESY`, 32, lines per frame (≥1)
- Derived localparams: `PIXELS` = `RESX*RESY`; `AW` = clog2(`PIXELS`)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a frame; sampled only in IDLE
- `passes`  in  8  pass count, latched on `start`; 0 treated as 1
- `busy`  out  1  high from the cycle after `start` until `done`
- `done`  out  1  one-cycle pulse when all issued pixels have retired
- `err`  out  1  sticky: `output_ready` seen while IDLE; cleared by `start`
- `pvalid`  out  1  issue strobe; the core treats `pvalid=0` as a bubble
- `xin`, `yin`  out  11 each  issue coordinates
- `pin_sel`  out  1  0 = feed zero state (pass 0); 1 = feed framebuffer read data
- `rd_addr`  out  AW  `yin*RESX+xin`, combinational from `xin`/`yin`
- `pass`  out  8  current issue pass index
- `output_ready`  in  1  core retires one pixel this cycle
- `wr_en`  out  1  `output_ready && busy`
- `wr_addr`  out  AW  `yout*RESX+xout`, combinational

## Operation
- States:
  - IDLE: waits for `start`.
  - ISSUE: issues pixels.
  - DRAIN: waits for all in-flight pixels to retire.
- IDLE→ISSUE on `start`: latch `passes` (0→1); zero issue and retire coordinates, `pass`, `inflight`; clear `err`.
- ISSUE issue rule: `pvalid = (inflight < PIXELS)`.
  - On an issue, x increments; at `RESX-1`, x wraps to 0 and y increments.
  - At y `RESY-1` with x `RESX-1`, y wraps to 0 and `pass` increments.
- ISSUE→DRAIN on the issue of the last pixel of pass `passes-1`.
- DRAIN→IDLE when `inflight==0`, with a registered `done` pulse. DRAIN holds `pvalid=0`.
- `inflight` counter:
  - +1 on issue, −1 on `wr_en`, unchanged when both occur.
  - Width AW+1, saturating range 0..`PIXELS`.
- Retire coordinates `xout`/`yout` use the same raster wrap, advanced on `wr_en`; they carry no pass.
- `pin_sel = (pass != 0)`.
- `start` while busy is ignored.
- `output_ready` in IDLE: `wr_en=0`, counters unchanged, `err` set.
- Retire when `inflight==0` in ISSUE/DRAIN: treated as a spurious retire; ignored, `err` set.
- Reset mid-frame: immediate return to IDLE, all state cleared. In-flight core results are dropped (`wr_en=0` once `busy=0`).

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` high at edge t → `busy` and first `pvalid` (x=0, y=0, pass=0) are visible after edge t.
- Issue throughput: 1 pixel/cycle while `inflight < PIXELS`.
- The retire decrement takes effect the cycle after `wr_en`. The earliest re-read of a pixel is therefore 1 cycle after its write, matching the synchronous-write framebuffer.
- `done` asserts the cycle after the last `wr_en`. `busy` drops in the same cycle as `done`.
- The scheduler assumes the core preserves in-order retirement. It makes no assumption about core latency.

## Structure
- `mandelbrot_pkg`: `COORD_W=11`, `PASS_W=8`, state enum (IDLE/ISSUE/DRAIN).
- Sub-module `mandelbrot_raster_counter` (params `RESX`, `RESY`):
  - Ports: `en` in; `x`, `y` out; `wrap` out, a pulse on frame wrap.
  - Instantiated twice: once for issue coordinates, once for retire coordinates.

## Test plan
Common bench config: `RESX=4`, `RESY=2` (PIXELS=8), unless noted.
1. Reset in IDLE, then pulse `start` with `passes=1` and a core model of latency 3 → 8 `pvalid` cycles (x 0..3, y 0..1, `pin_sel=0`); `wr_addr` sequence 0..7; `done` pulses 1 cycle after the 8th `wr_en`.
2. `passes=3`, latency 20 (> PIXELS) → issue stalls at `inflight=8`; no `rd_addr` N is issued before `wr_addr` N of the previous pass; 24 total issues; `pass` steps 0→1→2; `pin_sel=1` for passes 1–2.
3. `passes=0` → behaves exactly as `passes=1`: 8 issues, one `done`.
4. `output_ready` pulsed in IDLE → `err=1`, `wr_en=0`; the next `start` clears `err`.
5. `rst_n` low during pass 1 with 5 pixels in flight → all outputs 0 asynchronously. After release, later `output_ready` pulses give `wr_en=0`, set `err`, and no `done`.
6. `start` held high through the whole frame → exactly one frame runs. The `start` high in the cycle after `done` (IDLE) begins a second frame at x=0, y=0, pass=0.
